// File: rtl/prbs11_os_gen.sv
// PRBS11 ordered-set generator: emits DATA_W bits per clock (MSB earliest), restarting
// from SEED at every ordered-set boundary, with completion pulse, OS count and burst stop.
module prbs11_os_gen #(
   parameter int          DATA_W = 8,
   parameter int          OS_LEN = 448,
   parameter logic [10:0] SEED   = 11'h7FF,
   parameter int          NUM_OS = 0,
   parameter int          CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              os_sent,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  os_cnt
);

   localparam int                WORDS    = OS_LEN / DATA_W;
   localparam int                IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);
   localparam logic [31:0]       NUM_OS_L = 32'(NUM_OS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [10:0]         lfsr_q, lfsr_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                sent_q, sent_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [31:0]         burst_q, burst_d;

   logic [10:0]         lfsr_adv_s;
   logic [DATA_W-1:0]   word_s;
   logic                done_set_s;
   logic                start_s;
   logic                gen_s;
   logic                last_s;
   logic                fin_s;

   // Unroll DATA_W single-bit LFSR steps to form one output word
   always_comb begin
      lfsr_adv_s = lfsr_q;
      word_s     = '0;
      for (int i = 0; i < DATA_W; i++) begin
         word_s[DATA_W-1-i] = lfsr_adv_s[10];
         lfsr_adv_s         = {lfsr_adv_s[9:0], lfsr_adv_s[10] ^ lfsr_adv_s[8]};
      end
   end

   // Next-state and output decode for the IDLE/RUN/DRAIN sequencer
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      idx_d   = idx_q;
      data_d  = '0;
      valid_d = 1'b0;
      sent_d  = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = cnt_q;
      burst_d = burst_q;
      fin_s   = 1'b0;

      // done rises one cycle after the closing os_sent; that same cycle must not restart
      done_set_s = (NUM_OS_L != 32'd0) && sent_q && (burst_q == NUM_OS_L);
      start_s    = (state_q == IDLE) && enable && !done_q && !done_set_s;
      gen_s      = start_s || (state_q != IDLE);
      last_s     = (idx_q == LAST_IDX);

      if (enable) begin
         done_d = done_q || done_set_s;
      end else begin
         done_d = 1'b0;
      end

      if (gen_s) begin
         data_d  = word_s;
         valid_d = 1'b1;
         busy_d  = 1'b1;
         sent_d  = last_s;
         if (start_s) begin
            cnt_d   = CNT_W'(last_s);
            burst_d = 32'(last_s);
         end else begin
            cnt_d   = cnt_q + CNT_W'(last_s);
            burst_d = burst_q + 32'(last_s);
         end
         if (last_s) begin
            lfsr_d  = SEED;
            idx_d   = '0;
            fin_s   = (NUM_OS_L != 32'd0) && (burst_d == NUM_OS_L);
            state_d = (enable && !fin_s) ? RUN : IDLE;
         end else begin
            lfsr_d  = lfsr_adv_s;
            idx_d   = idx_q + IDX_W'(1);
            state_d = enable ? RUN : DRAIN;
         end
      end else begin
         state_d = IDLE;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         lfsr_q  <= SEED;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sent_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         burst_q <= 32'd0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sent_q  <= sent_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         burst_q <= burst_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign os_sent    = sent_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign os_cnt     = cnt_q;

endmodule

// File: tb/tb_prbs11_os_gen.sv
// Self-checking bench for prbs11_os_gen: lane-0/lane-1 byte instances, a bit-serial
// instance and a two-OS burst instance, checked against a recurrence-based reference.
module tb_prbs11_os_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic en_a, en1, en2;

   logic [7:0]  d0, d3, d2;
   logic [0:0]  d1;
   logic        v0, s0, b0, dn0;
   logic        v3, s3, b3, dn3;
   logic        v1, s1, b1, dn1;
   logic        v2, s2, b2, dn2;
   logic [15:0] c0, c3, c1, c2;

   prbs11_os_gen #(.DATA_W(8), .OS_LEN(448), .SEED(11'h7FF), .NUM_OS(0), .CNT_W(16)) u0 (
      .clk(clk), .reset(reset), .enable(en_a), .data_out(d0), .data_valid(v0),
      .os_sent(s0), .busy(b0), .done(dn0), .os_cnt(c0));
   prbs11_os_gen #(.DATA_W(8), .OS_LEN(448), .SEED(11'h770), .NUM_OS(0), .CNT_W(16)) u3 (
      .clk(clk), .reset(reset), .enable(en_a), .data_out(d3), .data_valid(v3),
      .os_sent(s3), .busy(b3), .done(dn3), .os_cnt(c3));
   prbs11_os_gen #(.DATA_W(1), .OS_LEN(448), .SEED(11'h7FF), .NUM_OS(0), .CNT_W(16)) u1 (
      .clk(clk), .reset(reset), .enable(en1), .data_out(d1), .data_valid(v1),
      .os_sent(s1), .busy(b1), .done(dn1), .os_cnt(c1));
   prbs11_os_gen #(.DATA_W(8), .OS_LEN(448), .SEED(11'h7FF), .NUM_OS(2), .CNT_W(16)) u2 (
      .clk(clk), .reset(reset), .enable(en2), .data_out(d2), .data_valid(v2),
      .os_sent(s2), .busy(b2), .done(dn2), .os_cnt(c2));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // OS bit stream from the polynomial recurrence s[n] = s[n-11] ^ s[n-9]
   function automatic logic [447:0] os_bits(input logic [10:0] seed);
      logic [447:0] s;
      s = '0;
      for (int n = 0; n < 11; n++) s[n] = seed[10-n];
      for (int n = 11; n < 448; n++) s[n] = s[n-11] ^ s[n-9];
      return s;
   endfunction

   function automatic logic [7:0] ref_word(input logic [447:0] b, input int k);
      logic [7:0] w;
      for (int i = 0; i < 8; i++) w[7-i] = b[8*k+i];
      return w;
   endfunction

   logic [447:0] ref0, ref3;

   // Control model: an OS once begun always finishes; a new one follows only while enabled
   bit m_active;
   int m_pos;
   int m_cnt;

   task automatic tick_a(input logic en);
      logic emit, sent;
      int   word;
      en_a = en;
      emit = m_active || en;
      sent = 1'b0;
      word = 0;
      if (emit) begin
         if (!m_active) begin
            m_cnt = 0;
            m_pos = 0;
         end
         word = m_pos;
         sent = (m_pos == 55);
         if (sent) begin
            m_cnt++;
            m_pos    = 0;
            m_active = en;
         end else begin
            m_pos++;
            m_active = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      chk("valid0", v0, emit);
      chk("busy0", b0, emit);
      chk("sent0", s0, sent);
      chk("cnt0", c0, m_cnt & 32'hFFFF);
      chk("done0", dn0, 1'b0);
      chk("data0", d0, emit ? ref_word(ref0, word) : 8'h00);
      chk("valid3", v3, emit);
      chk("busy3", b3, emit);
      chk("sent3", s3, sent);
      chk("cnt3", c3, m_cnt & 32'hFFFF);
      chk("done3", dn3, 1'b0);
      chk("data3", d3, emit ? ref_word(ref3, word) : 8'h00);
   endtask

   typedef struct {
      logic       en;
      logic       valid;
      logic [7:0] d0;
      logic [7:0] d3;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int   cnt_v;
      int   sends;
      int   words;
      bit   found;
      logic en_r;

      tbl[0] = '{en: 1'b0, valid: 1'b0, d0: 8'h00, d3: 8'h00};
      tbl[1] = '{en: 1'b1, valid: 1'b1, d0: 8'hFF, d3: 8'hEE};
      tbl[2] = '{en: 1'b1, valid: 1'b1, d0: 8'hE0, d3: 8'h0A};
      tbl[3] = '{en: 1'b1, valid: 1'b1, d0: 8'h0C, d3: 8'hC4};

      reset = 1'b0; en_a = 1'b0; en1 = 1'b0; en2 = 1'b0;
      m_active = 1'b0; m_pos = 0; m_cnt = 0;
      ref0 = os_bits(11'h7FF);
      ref3 = os_bits(11'h770);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", v0, 1'b0);
      chk("rst_data", d0, 8'h00);
      chk("rst_sent", s0, 1'b0);
      chk("rst_busy", b0, 1'b0);
      chk("rst_done", dn2, 1'b0);
      chk("rst_cnt", c0, 16'h0000);
      chk("rst_valid1", v1, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 4; i++) begin
         tick_a(tbl[i].en);
         chk("tbl_valid", v0, tbl[i].valid);
         chk("tbl_d0", d0, tbl[i].d0);
         chk("tbl_d3", d3, tbl[i].d3);
      end

      // Continuous run over two OS boundaries
      for (int w = 3; w <= 55; w++) tick_a(1'b1);
      chk("sent_w55", s0, 1'b1);
      chk("cnt_w55", c0, 16'd1);
      tick_a(1'b1);
      chk("reseed_d0", d0, 8'hFF);
      chk("reseed_d3", d3, 8'hEE);
      for (int w = 57; w <= 111; w++) tick_a(1'b1);
      chk("sent_w111", s0, 1'b1);
      chk("cnt_w111", c0, 16'd2);
      tick_a(1'b0);
      repeat (60) tick_a(1'b0);
      chk("drain3_valid", v0, 1'b0);
      chk("drain3_cnt", c0, 16'd3);

      // Enable dropped at word 20: the remainder of the OS still goes out
      for (int w = 0; w < 20; w++) tick_a(1'b1);
      cnt_v = 0;
      for (int c = 0; c < 40; c++) begin
         tick_a(1'b0);
         if (v0) cnt_v++;
      end
      chk("drop_words", cnt_v, 36);
      chk("drop_valid", v0, 1'b0);
      chk("drop_busy", b0, 1'b0);
      chk("drop_cnt", c0, 16'd1);

      // Random enable with long holds
      en_r = 1'b0;
      for (int c = 0; c < 700; c++) begin
         if ($urandom_range(0, 11) == 0) en_r = ~en_r;
         tick_a(en_r);
      end
      repeat (60) tick_a(1'b0);

      // Bit-serial instance over three ordered sets
      en1 = 1'b1;
      for (int n = 0; n < 3 * 448 + 1; n++) begin
         @(posedge clk);
         #1;
         chk("bit_data", d1, ref0[n % 448]);
         chk("bit_valid", v1, 1'b1);
         chk("bit_busy", b1, 1'b1);
         chk("bit_sent", s1, (n % 448) == 447);
         chk("bit_cnt", c1, (n + 1) / 448);
         chk("bit_done", dn1, 1'b0);
         if (n == 448) chk("bit449", d1, 1'b1);
      end
      en1 = 1'b0;

      // Two-OS burst: stop, done timing, hold, clear and restart
      en2 = 1'b1;
      sends = 0; words = 0; found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(posedge clk);
         #1;
         if (v2) words++;
         if (s2) sends++;
         if (sends == 2) begin
            chk("done_with_sent", dn2, 1'b0);
            @(posedge clk);
            #1;
            chk("done_after_sent", dn2, 1'b1);
            chk("valid_after_burst", v2, 1'b0);
            found = 1'b1;
         end
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL burst_timeout: got %0d os_sent pulses expected 2", sends);
      end
      chk("burst_words", words, 112);
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("done_hold", dn2, 1'b1);
         chk("idle_valid2", v2, 1'b0);
         chk("idle_busy2", b2, 1'b0);
      end
      en2 = 1'b0;
      @(posedge clk);
      #1;
      chk("done_clear", dn2, 1'b0);
      chk("cnt_hold", c2, 16'd2);
      en2 = 1'b1;
      @(posedge clk);
      #1;
      chk("restart_valid", v2, 1'b1);
      chk("restart_cnt", c2, 16'd0);
      chk("restart_data", d2, 8'hFF);
      en2 = 1'b0;

      // Reset in the middle of an OS
      for (int w = 0; w < 30; w++) tick_a(1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", v0, 1'b0);
      chk("mid_rst_data", d0, 8'h00);
      chk("mid_rst_sent", s0, 1'b0);
      chk("mid_rst_busy", b0, 1'b0);
      chk("mid_rst_cnt", c0, 16'h0000);
      chk("mid_rst_d3", d3, 8'h00);
      m_active = 1'b0; m_pos = 0; m_cnt = 0;
      @(negedge clk);
      reset = 1'b1;
      tick_a(1'b1);
      chk("post_rst_d0", d0, 8'hFF);
      tick_a(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
